// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared widths, line/beat types and adaptor state encoding
package cache_types_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = 5;

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [BURST_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts one 256-bit cache line request into a 4-beat 64-bit burst
module cacheline_adaptor #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic [ADDR_WIDTH-1:0]  bmem_address,
    output logic                   bmem_read,
    output logic                   bmem_write,
    output logic [BURST_WIDTH-1:0] bmem_wdata,
    input  logic [BURST_WIDTH-1:0] bmem_rdata,
    input  logic                   bmem_resp
);
    import cache_types_pkg::*;

    localparam int CNT_W = $clog2(BEATS);

    adaptor_state_t state, next_state;
    logic [CNT_W-1:0] count;
    logic [BEATS-1:0][BURST_WIDTH-1:0] line_buf, assembled;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] aligned_address;
    logic [OFFSET_BITS-1:0] unused_offset;
    logic last_beat;

    assign aligned_address = {pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offset   = pmem_address[OFFSET_BITS-1:0];
    assign last_beat       = (count == CNT_W'(BEATS-1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pmem_read)
                    next_state = RD_BURST;
                else if (pmem_write)
                    next_state = WR_BURST;
            end
            RD_BURST, WR_BURST: begin
                if (bmem_resp && last_beat)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Line as it will look once the current read beat is written in; also
    // the source for pmem_rdata on the final beat so no extra cycle is needed.
    always_comb begin
        assembled        = line_buf;
        assembled[count] = bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            line_buf     <= '0;
            bmem_address <= '0;
            rdata_q      <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        bmem_address <= aligned_address;
                        count        <= '0;
                        if (!pmem_read)
                            line_buf <= pmem_wdata;
                    end
                end
                RD_BURST: begin
                    if (bmem_resp) begin
                        line_buf <= assembled;
                        count    <= count + 1'b1;
                        if (last_beat)
                            rdata_q <= assembled;
                    end
                end
                WR_BURST: begin
                    if (bmem_resp)
                        count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bmem_read  = (state == RD_BURST);
    assign bmem_write = (state == WR_BURST);
    assign pmem_resp  = (state == DONE);
    assign bmem_wdata = bmem_write ? line_buf[count] : '0;
    assign pmem_rdata = rdata_q;

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Responder on the cache's physical-memory line interface.
- Accepts one 256-bit line read or write from the cache, identified by the pmem_* handshake.
- Converts that line into a 4-beat, 64-bit burst transaction on the main-memory side (bmem_*).
- Sits between the cache and the DRAM model / memory controller; has exactly one outstanding transaction.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, width of one burst beat in bits.
- BEATS (derived), LINE_WIDTH/BURST_WIDTH = 4, beats per line. Not overridable.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pmem_address  in  ADDR_WIDTH  line address from cache.
- pmem_read  in  1  line read request, held until pmem_resp.
- pmem_write  in  1  line write request, held until pmem_resp.
- pmem_wdata  in  LINE_WIDTH  line write data, stable while pmem_write is high.
- pmem_rdata  out  LINE_WIDTH  assembled read line.
- pmem_resp  out  1  one-cycle completion pulse.
- bmem_address  out  ADDR_WIDTH  burst base address.
- bmem_read  out  1  burst read request.
- bmem_write  out  1  burst write request.
- bmem_wdata  out  BURST_WIDTH  current write beat.
- bmem_rdata  in  BURST_WIDTH  current read beat, valid when bmem_resp is high.
- bmem_resp  in  1  beat accepted / beat valid.

Behaviour:
- States: IDLE, RD_BURST, WR_BURST, DONE.
- Reset:
  - Any cycle with rst=1 forces IDLE and beat count 0.
  - Outputs after reset: pmem_resp=0, bmem_read=0, bmem_write=0, bmem_address=0, bmem_wdata=0, pmem_rdata=0.
  - Reset mid-burst abandons the burst; bmem_read/bmem_write drop the cycle after rst is sampled.
- IDLE:
  - On sampling pmem_read=1: latch bmem_address = {pmem_address[31:5], 5'b0}, clear count, go to RD_BURST.
  - Else on sampling pmem_write=1: latch the address the same way, latch pmem_wdata into the line buffer, go to WR_BURST.
  - pmem_read and pmem_write both high is illegal; read wins.
- RD_BURST:
  - bmem_read=1 (registered; first asserted the cycle after the request is sampled).
  - Each cycle with bmem_resp=1: line_buf[count*64 +: 64] <= bmem_rdata; count++.
  - Gaps (bmem_resp=0) between beats are legal; count holds.
  - bmem_read drops the cycle after the 4th beat. Go to DONE.
- WR_BURST:
  - bmem_write=1; bmem_wdata = line_buf[count*64 +: 64] (beat 0 = bits 63:0).
  - count++ on each bmem_resp=1.
  - After the 4th resp, drop bmem_write and go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle.
  - On reads, pmem_rdata is the full assembled line and is held until the next read completes.
  - Next state is IDLE.
- Request retirement:
  - The cache retires its request on pmem_resp.
  - The adaptor is in IDLE for the cycle following the pulse and ignores pmem_read/pmem_write during the DONE cycle.
  - A new request is accepted no earlier than 1 cycle after the pulse.
- Latency:
  - Request sampled at edge t; bmem request high from t+1.
  - With zero-gap beats at t+1..t+4, pmem_resp is high in cycle t+5.
- Address and count:
  - bmem_address is constant for the whole burst.
  - count is 2 bits and wraps to 0 on the 4th beat.
  - bmem_resp while in IDLE or DONE is ignored.

Decomposition:
- Shared package cache_types_pkg:
  - LINE_WIDTH, BURST_WIDTH, BEATS, OFFSET_BITS=5.
  - typedef line_t (logic[255:0]), beat_t (logic[63:0]).
  - enum adaptor_state_t.
- No sub-module. A single FSM plus a beat counter and line buffer (≈150 lines).

Test Plan:
- Read:
  - Stimulus: pmem_read, address 0x40000804; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  - Required: bmem_address=0x40000800; pmem_rdata={0x44..,0x33..,0x22..,0x11..}; pmem_resp high 5 cycles after request, for 1 cycle.
- Write:
  - Stimulus: pmem_write, address 0x40008042, pmem_wdata=256'hf111.
  - Required: bmem_address=0x40008040; beats 0xf111, 0, 0, 0 in order; one pmem_resp after the 4th bmem_resp.
- Gapped read:
  - Stimulus: bmem_resp toggles 1,0,0,1,0,1,1.
  - Required: beats captured only on resp=1; pmem_resp one cycle after the last beat; bmem_read held throughout.
- Reset mid-burst:
  - Stimulus: rst after 2 read beats, then a new read at 0x40018040.
  - Required: bmem_read=0 the cycle after reset, no pmem_resp; the new read completes with correct data and count restarted.
- Back-to-back:
  - Stimulus: write then read of the same line, issued 1 cycle after the write's pmem_resp.
  - Required: read returns the written line; no spurious second transaction from the held request.
- Simultaneous read and write requests:
  - Stimulus: pmem_read and pmem_write high together.
  - Required: a read burst is issued; bmem_write stays 0.
